camera_pix_xfer_ctrl: RTL and testbench

//  Sequences pixel transfers from the D8M camera pixel stream to the Nios II over Avalon-MM.
//  - Software arms a transfer of LEN pixels. The block waits for start-of-frame, buffers pixels in a FIFO and raises done/irq when all LEN pixels are read.
//  - Sits between the camera RTL pipeline and the Nios pixel-transfer path.

---
 rtl/camera_pix_xfer_pkg.sv | 31 +++
 rtl/camera_pix_xfer_ctrl_if.sv | 29 ++
 rtl/camera_pix_xfer_ctrl_fifo.sv | 60 ++++++
 rtl/camera_pix_xfer_ctrl.sv | 156 +++++++++++++++
 tb/tb_camera_pix_xfer_ctrl.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/camera_pix_xfer_pkg.sv
// Shared types and register-map constants for the camera pixel transfer controller.
package camera_pix_xfer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_XFER     = 2'd2,
        ST_DRAIN    = 2'd3
    } xfer_state_t;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_LEN    = 2'd1;
    localparam logic [1:0] ADDR_DATA   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int unsigned CTRL_START_BIT     = 0;
    localparam int unsigned CTRL_ABORT_BIT     = 1;
    localparam int unsigned CTRL_IRQ_EN_BIT    = 2;
    localparam int unsigned CTRL_FCNT_LSB      = 16;

    localparam int unsigned STAT_BUSY_BIT      = 0;
    localparam int unsigned STAT_DONE_BIT      = 1;
    localparam int unsigned STAT_UNDERFLOW_BIT = 3;
    localparam int unsigned STAT_LEVEL_LSB     = 8;

    // Clamp a FIFO level into the 8-bit STATUS field.
    function automatic logic [7:0] sat_level(input logic [8:0] lvl);
        return (lvl > 9'd255) ? 8'hFF : lvl[7:0];
    endfunction

endpackage

// File: rtl/camera_pix_xfer_ctrl_if.sv
// Avalon-MM register port plus camera pixel stream and status outputs.
interface camera_pix_xfer_ctrl_if #(
    parameter int unsigned PIX_W = 24
);
    logic [1:0]       address;
    logic             chipselect;
    logic             write_n;
    logic             read_n;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic [PIX_W-1:0] pix_in_data;
    logic             pix_in_sof;
    logic             pix_in_valid;
    logic             pix_in_ready;
    logic             busy;
    logic             irq;

    modport master (
        output address, chipselect, write_n, read_n, writedata,
        output pix_in_data, pix_in_sof, pix_in_valid,
        input  readdata, pix_in_ready, busy, irq
    );

    modport slave (
        input  address, chipselect, write_n, read_n, writedata,
        input  pix_in_data, pix_in_sof, pix_in_valid,
        output readdata, pix_in_ready, busy, irq
    );
endinterface

// File: rtl/camera_pix_xfer_ctrl_fifo.sv
// Synchronous first-word-fall-through pixel FIFO with flush and occupancy count.
module camera_pix_fifo #(
    parameter int unsigned PIX_W = 24,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [PIX_W-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [PIX_W-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned LVL_W = AW + 1;

    logic [PIX_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LVL_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == LVL_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];
    assign level   = count;

    // Pointer and occupancy bookkeeping; flush empties the queue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array, written on accepted pushes.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/camera_pix_xfer_ctrl.sv
// Camera-to-Nios pixel transfer sequencer: arm LEN pixels, wait for SOF,
// buffer into a FIFO read over Avalon-MM, flag done/irq when drained.
// Optional feature macro PIX_XFER_FRAME_CNT_EN: completed-transfer counter on CTRL[31:16].
module camera_pix_xfer_ctrl
    import camera_pix_xfer_pkg::*;
#(
    parameter int unsigned PIX_W      = 24,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned LEN_W      = 20
) (
    input  logic                   clk,
    input  logic                   reset,
    camera_pix_xfer_ctrl_if.slave  bus
);
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    xfer_state_t      state;
    logic [LEN_W-1:0] remaining;
    logic [LEN_W-1:0] len_q;
    logic             irq_en;
    logic             done;
    logic             underflow;
    logic             alive;
    logic [15:0]      frame_cnt;

    logic             wr_en, rd_en;
    logic             ctrl_wr, stat_wr;
    logic             start_req, abort_req;
    logic             data_rd;
    logic             accept;
    logic             last_pix;
    logic             done_set;
    logic             fifo_push, fifo_pop;
    logic             fifo_full, fifo_empty;
    logic [PIX_W-1:0] fifo_head;
    logic [LVL_W-1:0] fifo_level;
    logic [31:0]      rdata;
    logic             unused_wdata;

    assign wr_en     = bus.chipselect & ~bus.write_n;
    assign rd_en     = bus.chipselect & ~bus.read_n;
    assign ctrl_wr   = wr_en & (bus.address == ADDR_CTRL);
    assign stat_wr   = wr_en & (bus.address == ADDR_STATUS);
    assign abort_req = ctrl_wr & bus.writedata[CTRL_ABORT_BIT];
    assign start_req = ctrl_wr & bus.writedata[CTRL_START_BIT] & ~bus.writedata[CTRL_ABORT_BIT];
    assign data_rd   = rd_en & (bus.address == ADDR_DATA);
    assign fifo_pop  = data_rd & ~fifo_empty;
    assign last_pix  = (remaining == LEN_W'(1));
    assign done_set  = (state == ST_DRAIN) & fifo_empty & ~abort_req;
    assign unused_wdata = ^bus.writedata;

    // Ready depends on registered state and FIFO count only; held low until out of reset.
    assign bus.pix_in_ready = alive & ((state == ST_XFER) ? ~fifo_full : 1'b1);
    assign accept    = bus.pix_in_valid & bus.pix_in_ready;
    assign fifo_push = accept & ~abort_req &
                       (((state == ST_WAIT_SOF) & bus.pix_in_sof) | (state == ST_XFER));

    assign bus.busy  = (state != ST_IDLE);
    assign bus.irq   = done & irq_en;

    camera_pix_fifo #(
        .PIX_W (PIX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (bus.pix_in_data),
        .pop       (fifo_pop),
        .flush     (abort_req),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // Transfer sequencer; ABORT overrides every state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            remaining <= '0;
        end else if (abort_req) begin
            state     <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_req && (len_q != '0)) begin
                        state     <= ST_WAIT_SOF;
                        remaining <= len_q;
                    end
                end
                ST_WAIT_SOF, ST_XFER: begin
                    if (fifo_push) begin
                        remaining <= remaining - LEN_W'(1);
                        state     <= last_pix ? ST_DRAIN : ST_XFER;
                    end
                end
                ST_DRAIN: begin
                    if (fifo_empty) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Software-visible registers and sticky flags; hardware set beats W1C.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_q     <= '0;
            irq_en    <= 1'b0;
            done      <= 1'b0;
            underflow <= 1'b0;
            alive     <= 1'b0;
        end else begin
            alive <= 1'b1;
            if (wr_en && (bus.address == ADDR_LEN)) len_q <= bus.writedata[LEN_W-1:0];
            if (ctrl_wr) irq_en <= bus.writedata[CTRL_IRQ_EN_BIT];
            done      <= done_set |
                         (done & ~(stat_wr & bus.writedata[STAT_DONE_BIT]));
            underflow <= (data_rd & fifo_empty) |
                         (underflow & ~(stat_wr & bus.writedata[STAT_UNDERFLOW_BIT]));
        end
    end

`ifdef PIX_XFER_FRAME_CNT_EN
    // Completed-transfer counter, bumped on each DRAIN to IDLE exit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         frame_cnt <= '0;
        else if (done_set) frame_cnt <= frame_cnt + 16'd1;
    end
`else
    assign frame_cnt = '0;
`endif

    // Zero-wait-state read mux.
    always_comb begin
        rdata = '0;
        case (bus.address)
            ADDR_CTRL: begin
                rdata[CTRL_IRQ_EN_BIT]             = irq_en;
                rdata[CTRL_FCNT_LSB +: 16]         = frame_cnt;
            end
            ADDR_LEN:  rdata = 32'(len_q);
            ADDR_DATA: rdata = fifo_empty ? 32'd0 : 32'(fifo_head);
            default: begin
                rdata[STAT_BUSY_BIT]               = bus.busy;
                rdata[STAT_DONE_BIT]               = done;
                rdata[STAT_UNDERFLOW_BIT]          = underflow;
                rdata[STAT_LEVEL_LSB +: 8]         = sat_level(9'(fifo_level));
            end
        endcase
    end

    assign bus.readdata = rdata;

endmodule

// File: tb/tb_camera_pix_xfer_ctrl.sv
// Scoreboard bench for camera_pix_xfer_ctrl: reads queue their expected data,
// a negedge monitor pops and compares whenever a read strobe is on the bus.
module tb_camera_pix_xfer_ctrl;
    localparam int unsigned PIX_W = 24;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    camera_pix_xfer_ctrl_if #(.PIX_W(PIX_W)) bus();

    camera_pix_xfer_ctrl #(
        .PIX_W      (PIX_W),
        .FIFO_DEPTH (16),
        .LEN_W      (20)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int unsigned  n_pass  = 0;
    int unsigned  n_total = 0;
    logic [31:0]  exp_q[$];
    string        name_q[$];
    logic [31:0]  mon_exp;
    string        mon_name;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    endtask

    // Monitor: every read strobe consumes one scoreboard entry.
    always @(negedge clk) begin
        if (bus.chipselect === 1'b1 && bus.read_n === 1'b0) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_read: got 0x%08h, required no read", bus.readdata);
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_name = name_q.pop_front();
                check(mon_name, bus.readdata, mon_exp);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        cyc();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
        exp_q.push_back(exp);
        name_q.push_back(name);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.read_n     = 1'b0;
        cyc();
        bus.chipselect = 1'b0;
        bus.read_n     = 1'b1;
    endtask

    task automatic pix(input logic [PIX_W-1:0] d, input logic sof);
        logic r;
        logic ok;
        ok               = 1'b0;
        bus.pix_in_data  = d;
        bus.pix_in_sof   = sof;
        bus.pix_in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            r = bus.pix_in_ready;
            @(posedge clk);
            #1;
            if (r) begin
                ok = 1'b1;
                break;
            end
        end
        bus.pix_in_valid = 1'b0;
        bus.pix_in_sof   = 1'b0;
        if (!ok) begin
            n_total++;
            $display("FAIL pix_accept: ready stayed 0 for pixel 0x%06h, required 1", d);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, required $finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.address      = 2'd0;
        bus.chipselect   = 1'b0;
        bus.write_n      = 1'b1;
        bus.read_n       = 1'b1;
        bus.writedata    = '0;
        bus.pix_in_data  = '0;
        bus.pix_in_sof   = 1'b0;
        bus.pix_in_valid = 1'b0;
        reset            = 1'b1;

        // Outputs during reset
        #2;
        check("rst_ready", 32'(bus.pix_in_ready), 32'd0);
        check("rst_busy",  32'(bus.busy), 32'd0);
        check("rst_irq",   32'(bus.irq), 32'd0);
        check("rst_ctrl",  bus.readdata, 32'd0);
        bus.address = 2'd3;
        #1;
        check("rst_status", bus.readdata, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        cyc();
        rd(2'd0, 32'h0, "idle_ctrl");
        rd(2'd1, 32'h0, "idle_len");
        rd(2'd3, 32'h0, "idle_status");
        check("idle_ready", 32'(bus.pix_in_ready), 32'd1);

        // 1: SOF gating and in-order delivery
        wr(2'd1, 32'd4);
        wr(2'd0, 32'h1);
        check("t1_busy", 32'(bus.busy), 32'd1);
        pix(24'h0000AA, 1'b0);
        pix(24'h0000BB, 1'b0);
        pix(24'h0000CC, 1'b0);
        rd(2'd3, 32'h0000_0001, "t1_status_dropped");
        pix(24'h112233, 1'b1);
        pix(24'h445566, 1'b0);
        pix(24'h778899, 1'b0);
        pix(24'hAABBCC, 1'b0);
        rd(2'd3, 32'h0000_0401, "t1_status_drain");
        rd(2'd2, 32'h0011_2233, "t1_data0");
        rd(2'd2, 32'h0044_5566, "t1_data1");
        rd(2'd2, 32'h0077_8899, "t1_data2");
        rd(2'd2, 32'h00AA_BBCC, "t1_data3");
        cyc();
        rd(2'd3, 32'h0000_0002, "t1_status_done");
        check("t1_busy_end", 32'(bus.busy), 32'd0);
        wr(2'd3, 32'h2);

        // 2: backpressure at full, release after one pop, irq on completion
        wr(2'd1, 32'd20);
        wr(2'd0, 32'h5);
        for (int i = 0; i < 16; i++) pix(24'hA00000 + 24'(i), (i == 0));
        check("t2_ready_full", 32'(bus.pix_in_ready), 32'd0);
        rd(2'd3, 32'h0000_1001, "t2_status_full");
        rd(2'd2, 32'h00A0_0000, "t2_data0");
        check("t2_ready_after_pop", 32'(bus.pix_in_ready), 32'd1);
        pix(24'hA00010, 1'b0);
        for (int i = 1; i < 5; i++) rd(2'd2, 32'h00A0_0000 + 32'(i), "t2_data_a");
        for (int i = 17; i < 20; i++) pix(24'hA00000 + 24'(i), 1'b0);
        for (int i = 5; i < 20; i++) rd(2'd2, 32'h00A0_0000 + 32'(i), "t2_data_b");
        cyc();
        check("t2_irq", 32'(bus.irq), 32'd1);
        rd(2'd3, 32'h0000_0002, "t2_status_done");
        wr(2'd3, 32'h2);
        check("t2_irq_cleared", 32'(bus.irq), 32'd0);

        // 3: underflow on empty DATA read, W1C
        rd(2'd2, 32'h0, "t3_data_empty");
        rd(2'd3, 32'h0000_0008, "t3_underflow");
        wr(2'd3, 32'h8);
        rd(2'd3, 32'h0, "t3_underflow_clr");

        // 4: ABORT+START mid-XFER
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h1);
        pix(24'hC00000, 1'b1);
        for (int i = 1; i < 5; i++) pix(24'hC00000 + 24'(i), 1'b0);
        rd(2'd3, 32'h0000_0501, "t4_status_xfer");
        wr(2'd0, 32'h3);
        check("t4_busy_abort", 32'(bus.busy), 32'd0);
        rd(2'd3, 32'h0, "t4_status_abort");

        // 5: LEN=0 START ignored; START/LEN while busy leave remaining alone
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h1);
        rd(2'd3, 32'h0, "t5_len0_idle");
        wr(2'd1, 32'd3);
        wr(2'd0, 32'h1);
        pix(24'hD00000, 1'b1);
        pix(24'hD00001, 1'b0);
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h1);
        pix(24'hD00002, 1'b0);
        pix(24'hD00003, 1'b0);
        rd(2'd3, 32'h0000_0301, "t5_status_drain");
        rd(2'd1, 32'd5, "t5_len_reg");
        rd(2'd2, 32'h00D0_0000, "t5_data0");
        rd(2'd2, 32'h00D0_0001, "t5_data1");
        rd(2'd2, 32'h00D0_0002, "t5_data2");
        cyc();
        rd(2'd3, 32'h0000_0002, "t5_status_done");
        wr(2'd3, 32'h2);

        // 6: completed-transfer count (tests 1, 2, 5), then reset mid-XFER
`ifdef PIX_XFER_FRAME_CNT_EN
        rd(2'd0, 32'h0003_0000, "t6_frame_cnt");
`else
        rd(2'd0, 32'h0000_0000, "t6_frame_cnt");
`endif
        wr(2'd1, 32'd4);
        wr(2'd0, 32'h5);
        pix(24'hE00000, 1'b1);
        pix(24'hE00001, 1'b0);
        check("t6_busy_pre", 32'(bus.busy), 32'd1);
        bus.address = 2'd0;
        reset = 1'b1;
        #1;
        check("t6_rst_busy",  32'(bus.busy), 32'd0);
        check("t6_rst_irq",   32'(bus.irq), 32'd0);
        check("t6_rst_ready", 32'(bus.pix_in_ready), 32'd0);
        check("t6_rst_ctrl",  bus.readdata, 32'd0);
        cyc();
        reset = 1'b0;
        cyc();
        rd(2'd3, 32'h0, "t6_status_post");
        rd(2'd0, 32'h0, "t6_ctrl_post");
        rd(2'd1, 32'h0, "t6_len_post");

        cyc();
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
